// File: rtl/pipe_stage_elastic.sv
// Elastic two-entry pipeline stage (MAIN head + SKID) with synchronous flush and sticky halt.
// Latency: 1 cycle from acceptance to output; 1 entry/cycle while out_ready stays high.
// Backpressure: in_ready is registered; low when both entries are held or once a halt has left.
module pipe_stage_elastic #(
    parameter int                  INSTR_W   = 16,
    parameter int                  DATA_W    = 16,
    parameter int                  REG_W     = 3,
    parameter int                  CTRL_W    = 12,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = 16'h0800
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DATA_W-1:0]   in_addr,
    input  logic [REG_W-1:0]    in_rd,
    input  logic [REG_W-1:0]    in_rs,
    input  logic [CTRL_W-1:0]   in_ctrl,
    input  logic                in_halt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [DATA_W-1:0]   out_data,
    output logic [DATA_W-1:0]   out_addr,
    output logic [REG_W-1:0]    out_rd,
    output logic [REG_W-1:0]    out_rs,
    output logic [CTRL_W-1:0]   out_ctrl,
    output logic                out_halt,
    output logic [1:0]          occupancy,
    output logic                halted
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [DATA_W-1:0]  data;
        logic [DATA_W-1:0]  addr;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   rs;
        logic [CTRL_W-1:0]  ctrl;
        logic               halt;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_ent;
    logic   in_ready_q, in_ready_d;
    logic   halted_q, halted_d;
    logic   in_fire, out_fire;

    assign in_ent   = {in_instr, in_data, in_addr, in_rd, in_rs, in_ctrl, in_halt};
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        halted_d = halted_q | (out_fire & main_q.halt);
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_ent;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_ent;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_d  = in_ent;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over any incoming transfer; a departing head still counts toward halted.
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
        in_ready_d = (state_d != FULL) && !halted_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            halted_q   <= halted_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign halted    = halted_q;
    assign occupancy = state_q;
    assign out_valid = (state_q != EMPTY);

    // Bubble outputs whenever the head is empty so stale MAIN contents never leak.
    assign out_instr = out_valid ? main_q.instr : NOP_INSTR;
    assign out_data  = out_valid ? main_q.data  : '0;
    assign out_addr  = out_valid ? main_q.addr  : '0;
    assign out_rd    = out_valid ? main_q.rd    : '0;
    assign out_rs    = out_valid ? main_q.rs    : '0;
    assign out_ctrl  = out_valid ? main_q.ctrl  : '0;
    assign out_halt  = out_valid ? main_q.halt  : 1'b0;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed scenarios plus randomized traffic against a queue model.
module tb_pipe_stage_elastic;

    localparam logic [15:0] NOP = 16'h0800;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] data;
        logic [15:0] addr;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [11:0] ctrl;
        logic        halt;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    ent_t in_e = '0;

    logic        in_ready, out_valid, out_halt, halted;
    logic [15:0] out_instr, out_data, out_addr;
    logic [2:0]  out_rd, out_rs;
    logic [11:0] out_ctrl;
    logic [1:0]  occupancy;

    pipe_stage_elastic dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_e.instr), .in_data(in_e.data), .in_addr(in_e.addr),
        .in_rd(in_e.rd), .in_rs(in_e.rs), .in_ctrl(in_e.ctrl), .in_halt(in_e.halt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_data(out_data), .out_addr(out_addr),
        .out_rd(out_rd), .out_rs(out_rs), .out_ctrl(out_ctrl), .out_halt(out_halt),
        .occupancy(occupancy), .halted(halted)
    );

    always #5 clk = ~clk;

    ent_t mq[$];
    bit   halted_m = 1'b0;
    bit   rdy_m = 1'b0;
    int   pass_cnt = 0;
    int   chk_cnt = 0;

    // Reference: a FIFO of at most two entries; acceptance allowed when the
    // previous cycle ended with room and no halt delivered.
    task automatic model_edge();
        bit in_fire, out_fire;
        if (!rst) begin
            mq.delete();
            halted_m = 1'b0;
            rdy_m    = 1'b0;
            return;
        end
        in_fire  = in_valid && rdy_m && !flush;
        out_fire = (mq.size() > 0) && out_ready;
        if (out_fire) begin
            if (mq[0].halt) halted_m = 1'b1;
            void'(mq.pop_front());
        end
        if (flush) mq.delete();
        else if (in_fire) mq.push_back(in_e);
        rdy_m = (mq.size() < 2) && !halted_m;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic logic [71:0] exp_vec();
        ent_t       h;
        logic       v;
        logic [1:0] occ;
        v   = (mq.size() != 0);
        occ = 2'(mq.size());
        if (v) h = mq[0];
        else begin
            h       = '0;
            h.instr = NOP;
        end
        return {v, occ, rdy_m, halted_m, h};
    endfunction

    function automatic logic [71:0] dut_vec();
        return {out_valid, occupancy, in_ready, halted, out_instr, out_data, out_addr,
                out_rd, out_rs, out_ctrl, out_halt};
    endfunction

    function automatic ent_t mk(logic [15:0] instr, logic halt);
        ent_t e;
        e.instr = instr;
        e.data  = 16'($urandom);
        e.addr  = 16'($urandom);
        e.rd    = 3'($urandom);
        e.rs    = 3'($urandom);
        e.ctrl  = 12'($urandom);
        e.halt  = halt;
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        #1;
        chk_cnt++;
        if ({out_valid, occupancy, in_ready, halted, out_instr} !== {1'b0, 2'd0, 1'b0, 1'b0, NOP})
            $display("FAIL reset_state got=%h exp=%h", {out_valid, occupancy, in_ready, halted, out_instr},
                     {1'b0, 2'd0, 1'b0, 1'b0, NOP});
        else pass_cnt++;
        chk_cnt++;
        if (dut_vec() !== exp_vec()) $display("FAIL reset_vec got=%h exp=%h", dut_vec(), exp_vec());
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL ready_after_reset got=%b exp=1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_e = mk(16'(16'h1000 + k), 1'b0);
            step();
            chk_cnt++;
            if ({out_valid, occupancy, out_instr} !== {1'b1, 2'd1, 16'(16'h1000 + k)})
                $display("FAIL stream_%0d got=%h exp=%h", k, {out_valid, occupancy, out_instr},
                         {1'b1, 2'd1, 16'(16'h1000 + k)});
            else pass_cnt++;
            chk_cnt++;
            if (dut_vec() !== exp_vec()) $display("FAIL stream_vec_%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            else pass_cnt++;
        end
        in_valid = 1'b0;
        step();
        chk_cnt++;
        if (dut_vec() !== exp_vec()) $display("FAIL stream_drain got=%h exp=%h", dut_vec(), exp_vec());
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        ent_t a, b, c;
        a = mk(16'hA000, 1'b0);
        b = mk(16'hA001, 1'b0);
        c = mk(16'hA002, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_e = a;
        step();
        in_e = b;
        step();
        chk_cnt++;
        if ({in_ready, occupancy} !== {1'b0, 2'd2})
            $display("FAIL bp_full got=%h exp=%h", {in_ready, occupancy}, {1'b0, 2'd2});
        else pass_cnt++;
        in_e = c;
        step();
        chk_cnt++;
        if ({out_instr, occupancy} !== {a.instr, 2'd2})
            $display("FAIL bp_hold got=%h exp=%h", {out_instr, occupancy}, {a.instr, 2'd2});
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        chk_cnt++;
        if ({out_valid, out_instr} !== {1'b1, b.instr}) $display("FAIL bp_b got=%h exp=%h", out_instr, b.instr);
        else pass_cnt++;
        step();
        chk_cnt++;
        if ({out_valid, out_instr} !== {1'b1, c.instr}) $display("FAIL bp_c got=%h exp=%h", out_instr, c.instr);
        else pass_cnt++;
        chk_cnt++;
        if (dut_vec() !== exp_vec()) $display("FAIL bp_vec got=%h exp=%h", dut_vec(), exp_vec());
        else pass_cnt++;
        in_valid = 1'b0;
        step();
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_empty got=%b exp=0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_e = mk(16'hB000, 1'b0);
        step();
        in_e = mk(16'hB001, 1'b0);
        step();
        flush = 1'b1;
        in_e  = mk(16'hBEEF, 1'b0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk_cnt++;
        if ({occupancy, out_valid, out_instr, out_ctrl} !== {2'd0, 1'b0, NOP, 12'd0})
            $display("FAIL flush_bubble got=%h exp=%h", {occupancy, out_valid, out_instr, out_ctrl},
                     {2'd0, 1'b0, NOP, 12'd0});
        else pass_cnt++;
        chk_cnt++;
        if (dut_vec() !== exp_vec()) $display("FAIL flush_vec got=%h exp=%h", dut_vec(), exp_vec());
        else pass_cnt++;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_cnt++;
            if (out_valid !== 1'b0) $display("FAIL flush_no_output_%0d got=%b exp=0", k, out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_halt();
        ent_t x;
        x = mk(16'hC001, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_e = mk(16'hC000, 1'b1);
        step();
        in_e = x;
        step();
        in_e = mk(16'hC002, 1'b0);
        out_ready = 1'b1;
        step();
        chk_cnt++;
        if ({halted, in_ready, out_instr} !== {1'b1, 1'b0, x.instr})
            $display("FAIL halt_set got=%h exp=%h", {halted, in_ready, out_instr}, {1'b1, 1'b0, x.instr});
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_cnt++;
            if (dut_vec() !== exp_vec()) $display("FAIL halt_drain_%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            else pass_cnt++;
        end
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL halt_y_rejected got=%b exp=0", out_valid);
        else pass_cnt++;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk_cnt++;
        if (halted !== 1'b1) $display("FAIL halt_sticky_flush got=%b exp=1", halted);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        rst = 1'b0;
        model_edge();
        step();
        rst = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_e = mk(16'hD000, 1'b0);
        step();
        in_e = mk(16'hD001, 1'b0);
        step();
        in_valid = 1'b0;
        chk_cnt++;
        if (occupancy !== 2'd2) $display("FAIL ar_full got=%0d exp=2", occupancy);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1 model_edge();
        chk_cnt++;
        if ({out_valid, occupancy, in_ready, halted, out_instr, out_ctrl, out_data} !==
            {1'b0, 2'd0, 1'b0, 1'b0, NOP, 12'd0, 16'd0})
            $display("FAIL ar_immediate got=%h exp=%h",
                     {out_valid, occupancy, in_ready, halted, out_instr, out_ctrl, out_data},
                     {1'b0, 2'd0, 1'b0, 1'b0, NOP, 12'd0, 16'd0});
        else pass_cnt++;
        step();
        chk_cnt++;
        if (dut_vec() !== exp_vec()) $display("FAIL ar_held got=%h exp=%h", dut_vec(), exp_vec());
        else pass_cnt++;
        rst = 1'b1;
        step();
        chk_cnt++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL ar_release got=%b exp=10", {in_ready, out_valid});
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) < 2);
            in_e      = mk(16'($urandom), 1'b0);
            step();
            chk_cnt++;
            if (dut_vec() !== exp_vec()) $display("FAIL rand_%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            else pass_cnt++;
            if (occupancy < 2'd2 && !halted) begin
                chk_cnt++;
                if (in_ready !== 1'b1) $display("FAIL rand_ready_%0d got=%b exp=1", cyc, in_ready);
                else pass_cnt++;
            end
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk_cnt++;
        if ({occupancy, out_valid} !== 3'b000) $display("FAIL rand_drain got=%b exp=000", {occupancy, out_valid});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_halt();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
